instruction_memory_sync: RTL and testbench
==========================================

// Module: instruction_memory_sync
// PURPOSE
//  Parametrised, synchronous-read instruction memory for the pipelined datapath IF stage.
//  Replaces the fixed combinational case-ROM with a writable word array:
//   - registered fetch with stall and flush
//   - program-load write port
//   - post-reset clear sequencer
//   - alignment, range and halt detection
//  Sits between the PC register and the IF/ID pipeline register; the loader is driven by the bench or boot logic.
// PARAMETERS
//  DATA_W     16        instruction width in bits
//  ADDR_W     16        byte-address width of fetch and load ports
//  DEPTH      256       number of instruction words (any value 1..2**(ADDR_W-1))
//  NOP_WORD   16'h0000  word returned on flush, out-of-range or misaligned fetch, and written by clear
//  HALT_WORD  16'hEFFF  instruction that sets halt_seen
// PORTS
//  clk          in   1       clock; all logic on rising edge
//  rst          in   1       synchronous, active-high reset
//  fetch_en     in   1       request fetch at fetch_addr
//  fetch_addr   in   ADDR_W  byte address; word index = fetch_addr[ADDR_W-1:1]
//  stall        in   1       hold instr/instr_valid/error outputs
//  flush        in   1       squash output to NOP
//  instr        out  DATA_W  fetched instruction
//  instr_valid  out  1       instr holds a fetched word
//  align_err    out  1       fetched address had bit 0 set
//  range_err    out  1       word index >= DEPTH
//  parity_err   out  1       stored parity mismatch (IMEM_PARITY_EN only)
//  halt_seen    out  1       sticky; HALT_WORD has been delivered
//  load_ready   out  1       memory accepts loads and fetches (RUN state)
//  load_we      in   1       write load_data at load_addr
//  load_addr    in   ADDR_W  byte address of load (bit 0 ignored)
//  load_data    in   DATA_W  word to write
// BEHAVIOUR
//  Reset (rst=1 at edge), which may occur mid-clear or mid-fetch:
//   - instr=NOP_WORD; instr_valid, align_err, range_err, parity_err, halt_seen, load_ready all 0
//   - FSM enters CLEAR with clear counter = 0
//  FSM:
//   - CLEAR: writes NOP_WORD to word[cnt] each cycle, cnt++. After word DEPTH-1 is written (DEPTH cycles
//     after reset deasserts), FSM goes to RUN and load_ready=1 from the next cycle.
//   - In CLEAR, fetch_en and load_we are ignored and instr_valid stays 0.
//   - RUN: stays in RUN until rst.
//  Fetch, RUN only; priority flush > stall > fetch_en:
//   - flush=1: next cycle instr=NOP_WORD, instr_valid=0, all err flags 0 (overrides stall)
//   - stall=1: all fetch outputs hold their values
//   - fetch_en=1 at edge N: outputs updated at edge N+1 (1-cycle latency)
//       - normal fetch: instr=word[idx], instr_valid=1
//       - fetch_addr[0]=1: instr=NOP_WORD, instr_valid=1, align_err=1
//       - else idx>=DEPTH: instr=NOP_WORD, instr_valid=1, range_err=1
//       - align takes precedence over range
//   - fetch_en=0 (no stall/flush): instr_valid=0; instr and err flags 0/NOP_WORD
//   - error flags are valid only in the cycle of the associated instr
//  Load, RUN only:
//   - word[load_addr[ADDR_W-1:1]] <= load_data
//   - index >= DEPTH: write dropped silently
//   - load is not affected by stall or flush
//  Load and fetch to the same word on the same edge: read-before-write; fetch returns the old contents.
//  halt_seen:
//   - set when a delivered instr==HALT_WORD with instr_valid=1
//   - cleared only by rst; stall/flush do not clear it
//  Width rules: idx is a zero-extended, unsigned ADDR_W-1 bit value; no wrap-around.
// CONFIGURATION
//  IMEM_PARITY_EN defined:
//   - array is DATA_W+1 wide; even parity is generated on load and clear writes
//   - on fetch, parity_err=1 alongside instr when recomputed parity != stored bit; instr still delivered
//   - parity_err=0 for NOP substitutions
//  IMEM_PARITY_EN undefined: array is DATA_W wide; parity_err tied 0; port still present.
// TESTING
//  1. rst 1 cycle, DEPTH=256 -> load_ready=0 for 256 cycles, then 1; fetch 0x0010 -> instr=0x0000 valid.
//  2. load 0x0000<=16'hF120, 0x0002<=16'hEFFF; fetch 0x0000, 0x0002 back-to-back
//     -> instr=F120 then EFFF, each 1 cycle later; halt_seen=1 after EFFF and stays 1.
//  3. fetch 0x0003 -> align_err=1, instr=0000; fetch 0x0200 (idx 256) -> range_err=1, instr=0000.
//  4. fetch F120 word, then stall 3 cycles with changing fetch_addr -> instr holds F120, valid=1;
//     flush with stall=1 -> next cycle instr=0000, valid=0.
//  5. same-edge load 0x0004<=16'h1234 (old 16'h9000) and fetch 0x0004 -> instr=9000;
//     refetch next cycle -> 1234.
//  6. rst asserted mid-clear and after halt -> all outputs 0/NOP, clear restarts at word 0, halt_seen=0;
//     with IMEM_PARITY_EN, force a stored parity bit flip -> parity_err=1 with the data.

Source files
------------

// File: rtl/instruction_memory_sync_if.sv
// Fetch/load bundle between the IF-stage PC logic, the program loader and the instruction memory.
// master drives fetch requests and loads; slave is the memory returning instr and status.
interface instruction_memory_sync_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic              fetch_en;
  logic [ADDR_W-1:0] fetch_addr;
  logic              stall;
  logic              flush;
  logic [DATA_W-1:0] instr;
  logic              instr_valid;
  logic              align_err;
  logic              range_err;
  logic              parity_err;
  logic              halt_seen;
  logic              load_ready;
  logic              load_we;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;

  modport master (
    output fetch_en, fetch_addr, stall, flush, load_we, load_addr, load_data,
    input  instr, instr_valid, align_err, range_err, parity_err, halt_seen, load_ready
  );

  modport slave (
    input  fetch_en, fetch_addr, stall, flush, load_we, load_addr, load_data,
    output instr, instr_valid, align_err, range_err, parity_err, halt_seen, load_ready
  );
endinterface

// File: rtl/instruction_memory_sync.sv
// Writable instruction memory: 1-cycle registered fetch (flush > stall > fetch_en), load port, post-reset clear.
// No backpressure beyond load_ready (low while clearing); optional stored parity under IMEM_PARITY_EN.
module instruction_memory_sync #(
  parameter int                DATA_W    = 16,
  parameter int                ADDR_W    = 16,
  parameter int                DEPTH     = 256,
  parameter logic [DATA_W-1:0] NOP_WORD  = '0,
  parameter logic [DATA_W-1:0] HALT_WORD = DATA_W'(16'hEFFF)
) (
  input logic                      clk,
  input logic                      rst,
  instruction_memory_sync_if.slave bus
);

  localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
  localparam logic [IDX_W-1:0]  LAST    = IDX_W'(DEPTH - 1);
`ifdef IMEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;

  // Even parity: the stored bit makes the XOR over the whole stored word zero.
  function automatic logic [MEM_W-1:0] encode(input logic [DATA_W-1:0] d);
`ifdef IMEM_PARITY_EN
    return {^d, d};
`else
    return d;
`endif
  endfunction

  logic [MEM_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              valid_q, valid_d;
  logic              align_q, align_d;
  logic              range_q, range_d;
  logic              parity_q, parity_d;
  logic              halt_q, halt_d;

  logic [ADDR_W-1:0] fetch_word, load_word;
  logic              fetch_in_range, load_in_range;
  logic [IDX_W-1:0]  fetch_idx, load_idx;
  logic [MEM_W-1:0]  rd_word;

  assign fetch_word     = {1'b0, bus.fetch_addr[ADDR_W-1:1]};
  assign load_word      = {1'b0, bus.load_addr[ADDR_W-1:1]};
  assign fetch_in_range = fetch_word < DEPTH_A;
  assign load_in_range  = load_word < DEPTH_A;
  assign fetch_idx      = IDX_W'(fetch_word);
  assign load_idx       = IDX_W'(load_word);
  assign rd_word        = mem[fetch_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    instr_d  = NOP_WORD;
    valid_d  = 1'b0;
    align_d  = 1'b0;
    range_d  = 1'b0;
    parity_d = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      default: begin
        if (bus.flush) begin
          instr_d = NOP_WORD;
        end else if (bus.stall) begin
          instr_d  = instr_q;
          valid_d  = valid_q;
          align_d  = align_q;
          range_d  = range_q;
          parity_d = parity_q;
        end else if (bus.fetch_en) begin
          valid_d = 1'b1;
          if (bus.fetch_addr[0]) begin
            align_d = 1'b1;
          end else if (!fetch_in_range) begin
            range_d = 1'b1;
          end else begin
            instr_d = rd_word[DATA_W-1:0];
`ifdef IMEM_PARITY_EN
            parity_d = ^rd_word;
`endif
          end
        end
      end
    endcase
    halt_d = halt_q | (valid_d && (instr_d == HALT_WORD));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q  <= NOP_WORD;
      valid_q  <= 1'b0;
      align_q  <= 1'b0;
      range_q  <= 1'b0;
      parity_q <= 1'b0;
      halt_q   <= 1'b0;
    end else begin
      instr_q  <= instr_d;
      valid_q  <= valid_d;
      align_q  <= align_d;
      range_q  <= range_d;
      parity_q <= parity_d;
      halt_q   <= halt_d;
    end
  end

  // Single write port; the fetch read above sees the pre-edge contents (read-before-write).
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == ST_CLEAR) begin
        mem[cnt_q] <= encode(NOP_WORD);
      end else if (bus.load_we && load_in_range) begin
        mem[load_idx] <= encode(bus.load_data);
      end
    end
  end

  assign bus.instr       = instr_q;
  assign bus.instr_valid = valid_q;
  assign bus.align_err   = align_q;
  assign bus.range_err   = range_q;
`ifdef IMEM_PARITY_EN
  assign bus.parity_err  = parity_q;
`else
  assign bus.parity_err  = 1'b0;
`endif
  assign bus.halt_seen   = halt_q;
  assign bus.load_ready  = (state_q == ST_RUN);

endmodule

// File: tb/tb_instruction_memory_sync.sv
// Randomised and directed bench for instruction_memory_sync against a word-array reference model.
// Parity scenario is compiled only when IMEM_PARITY_EN is defined.
module tb_instruction_memory_sync;
  localparam int          DATA_W = 16;
  localparam int          ADDR_W = 16;
  localparam int          DEPTH  = 256;
  localparam logic [15:0] NOP    = 16'h0000;
  localparam logic [15:0] HALT   = 16'hEFFF;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instruction_memory_sync_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  instruction_memory_sync #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model: plain word array plus the expected output registers.
  logic [15:0] m_mem [DEPTH];
  bit          m_bad [DEPTH];
  logic [15:0] e_instr;
  bit          e_valid, e_align, e_range, e_par, e_halt, m_run;
  int          m_clr;

  wire [21:0] obs = {bus.instr, bus.instr_valid, bus.align_err, bus.range_err,
                     bus.parity_err, bus.halt_seen, bus.load_ready};

  function automatic logic [21:0] exp_vec();
    return {e_instr, e_valid, e_align, e_range, e_par, e_halt, m_run};
  endfunction

  task automatic drive(input bit fe, input logic [15:0] fa, input bit st, input bit fl,
                       input bit we, input logic [15:0] la, input logic [15:0] ld);
    bus.fetch_en   = fe;
    bus.fetch_addr = fa;
    bus.stall      = st;
    bus.flush      = fl;
    bus.load_we    = we;
    bus.load_addr  = la;
    bus.load_data  = ld;
  endtask

  task automatic clear_outs();
    e_instr = NOP; e_valid = 0; e_align = 0; e_range = 0; e_par = 0;
  endtask

  // Advance one clock and update the model from the inputs seen at that edge.
  task automatic tick();
    int fidx, lidx;
    @(posedge clk);
    fidx = int'(bus.fetch_addr >> 1);
    lidx = int'(bus.load_addr >> 1);
    if (rst) begin
      clear_outs(); e_halt = 0; m_run = 0; m_clr = 0;
    end else if (!m_run) begin
      m_mem[m_clr] = NOP; m_bad[m_clr] = 0; m_clr++;
      if (m_clr == DEPTH) m_run = 1;
      clear_outs();
    end else begin
      if (bus.flush) clear_outs();
      else if (bus.stall) ;
      else if (bus.fetch_en) begin
        clear_outs(); e_valid = 1;
        if (bus.fetch_addr[0]) e_align = 1;
        else if (fidx >= DEPTH) e_range = 1;
        else begin e_instr = m_mem[fidx]; e_par = m_bad[fidx]; end
      end else clear_outs();
      if (e_valid && e_instr == HALT) e_halt = 1;
      if (bus.load_we && lidx < DEPTH) begin m_mem[lidx] = bus.load_data; m_bad[lidx] = 0; end
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1; drive(0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    n_checks++;
    if (obs !== 22'h0) begin n_errs++; $display("FAIL reset: got %h want %h", obs, 22'h0); end
    n_checks++;
    if (obs !== exp_vec()) begin n_errs++; $display("FAIL reset_model: got %h want %h", obs, exp_vec()); end
    rst = 0;
  endtask

  task automatic test_clear();
    for (int i = 0; i < DEPTH; i++) begin
      drive($urandom_range(0, 1), 16'($urandom_range(0, 511)), 0, 0,
            $urandom_range(0, 1), 16'($urandom_range(0, 511)), 16'($urandom));
      tick();
      n_checks++;
      if (obs !== exp_vec()) begin n_errs++; $display("FAIL clear[%0d]: got %h want %h", i, obs, exp_vec()); end
      if (i == DEPTH - 2) begin
        n_checks++;
        if (bus.load_ready !== 1'b0) begin n_errs++; $display("FAIL clear_ready_low: got %b want 0", bus.load_ready); end
      end
    end
    n_checks++;
    if (bus.load_ready !== 1'b1) begin n_errs++; $display("FAIL clear_ready_high: got %b want 1", bus.load_ready); end
    drive(1, 16'h0010, 0, 0, 0, 0, 0); tick();
    n_checks++;
    if (bus.instr !== 16'h0000 || bus.instr_valid !== 1'b1) begin
      n_errs++; $display("FAIL clear_fetch: got instr=%h valid=%b want 0000/1", bus.instr, bus.instr_valid);
    end
  endtask

  task automatic test_load_fetch();
    drive(0, 0, 0, 0, 1, 16'h0000, 16'hF120); tick();
    drive(0, 0, 0, 0, 1, 16'h0002, HALT); tick();
    n_checks++;
    if (obs !== exp_vec()) begin n_errs++; $display("FAIL load: got %h want %h", obs, exp_vec()); end
    drive(1, 16'h0000, 0, 0, 0, 0, 0); tick();
    n_checks++;
    if (bus.instr !== 16'hF120 || bus.instr_valid !== 1'b1 || bus.halt_seen !== 1'b0) begin
      n_errs++; $display("FAIL fetch0: got instr=%h valid=%b halt=%b want f120/1/0", bus.instr, bus.instr_valid, bus.halt_seen);
    end
    drive(1, 16'h0002, 0, 0, 0, 0, 0); tick();
    n_checks++;
    if (bus.instr !== HALT || bus.instr_valid !== 1'b1) begin
      n_errs++; $display("FAIL fetch2: got instr=%h valid=%b want efff/1", bus.instr, bus.instr_valid);
    end
    drive(0, 0, 0, 0, 0, 0, 0); tick(); tick();
    n_checks++;
    if (bus.halt_seen !== 1'b1 || bus.instr_valid !== 1'b0) begin
      n_errs++; $display("FAIL halt_sticky: got halt=%b valid=%b want 1/0", bus.halt_seen, bus.instr_valid);
    end
  endtask

  task automatic test_errors();
    logic [15:0] addrs [3] = '{16'h0003, 16'h0200, 16'h0201};
    logic [1:0]  flags [3] = '{2'b10, 2'b01, 2'b10};
    for (int i = 0; i < 3; i++) begin
      drive(1, addrs[i], 0, 0, 0, 0, 0); tick();
      n_checks++;
      if ({bus.align_err, bus.range_err} !== flags[i] || bus.instr !== NOP || bus.instr_valid !== 1'b1) begin
        n_errs++; $display("FAIL err[%h]: got align/range=%b%b instr=%h valid=%b want %b/0000/1",
                           addrs[i], bus.align_err, bus.range_err, bus.instr, bus.instr_valid, flags[i]);
      end
    end
  endtask

  task automatic test_stall_flush();
    drive(1, 16'h0000, 0, 0, 0, 0, 0); tick();
    for (int i = 0; i < 3; i++) begin
      drive($urandom_range(0, 1), 16'($urandom), 1, 0, 0, 0, 0); tick();
      n_checks++;
      if (bus.instr !== 16'hF120 || bus.instr_valid !== 1'b1) begin
        n_errs++; $display("FAIL stall[%0d]: got instr=%h valid=%b want f120/1", i, bus.instr, bus.instr_valid);
      end
    end
    drive(1, 16'h0000, 1, 1, 0, 0, 0); tick();
    n_checks++;
    if (bus.instr !== NOP || bus.instr_valid !== 1'b0 || bus.halt_seen !== 1'b1) begin
      n_errs++; $display("FAIL flush: got instr=%h valid=%b halt=%b want 0000/0/1", bus.instr, bus.instr_valid, bus.halt_seen);
    end
  endtask

  task automatic test_back_to_back_rbw();
    drive(0, 0, 0, 0, 1, 16'h0004, 16'h9000); tick();
    drive(1, 16'h0004, 0, 0, 1, 16'h0004, 16'h1234); tick();
    n_checks++;
    if (bus.instr !== 16'h9000) begin n_errs++; $display("FAIL rbw_old: got %h want 9000", bus.instr); end
    drive(1, 16'h0004, 0, 0, 0, 0, 0); tick();
    n_checks++;
    if (bus.instr !== 16'h1234) begin n_errs++; $display("FAIL rbw_new: got %h want 1234", bus.instr); end
  endtask

`ifdef IMEM_PARITY_EN
  task automatic test_parity();
    drive(0, 0, 0, 0, 1, 16'h0006, 16'h00AA); tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    dut.mem[3][DATA_W] = ~dut.mem[3][DATA_W];
    m_bad[3] = 1;
    drive(1, 16'h0006, 0, 0, 0, 0, 0); tick();
    n_checks++;
    if (bus.parity_err !== 1'b1 || bus.instr !== 16'h00AA) begin
      n_errs++; $display("FAIL parity: got perr=%b instr=%h want 1/00aa", bus.parity_err, bus.instr);
    end
    drive(1, 16'h0008, 0, 0, 0, 0, 0); tick();
    n_checks++;
    if (obs !== exp_vec()) begin n_errs++; $display("FAIL parity_clean: got %h want %h", obs, exp_vec()); end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 1), 16'($urandom_range(0, 16'h021F)), ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 7) == 0), $urandom_range(0, 1), 16'($urandom_range(0, 16'h021F)),
            16'($urandom));
      tick();
      n_checks++;
      if (obs !== exp_vec()) begin n_errs++; $display("FAIL random[%0d]: got %h want %h", i, obs, exp_vec()); end
    end
  endtask

  task automatic test_reset_mid();
    drive(1, 16'h0000, 0, 0, 0, 0, 0);
    rst = 1; tick(); rst = 0;
    n_checks++;
    if (obs !== 22'h0) begin n_errs++; $display("FAIL rst_after_halt: got %h want %h", obs, 22'h0); end
    for (int i = 0; i < 100; i++) tick();
    n_checks++;
    if (obs !== exp_vec()) begin n_errs++; $display("FAIL mid_clear: got %h want %h", obs, exp_vec()); end
    rst = 1; tick(); rst = 0;
    n_checks++;
    if (obs !== 22'h0) begin n_errs++; $display("FAIL rst_mid_clear: got %h want %h", obs, 22'h0); end
    for (int i = 0; i < DEPTH; i++) begin
      tick();
      n_checks++;
      if (obs !== exp_vec()) begin n_errs++; $display("FAIL reclear[%0d]: got %h want %h", i, obs, exp_vec()); end
    end
    tick();
    n_checks++;
    if (bus.instr !== NOP || bus.instr_valid !== 1'b1 || bus.halt_seen !== 1'b0) begin
      n_errs++; $display("FAIL recleared_word: got instr=%h valid=%b halt=%b want 0000/1/0", bus.instr, bus.instr_valid, bus.halt_seen);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clear();
    test_load_fetch();
    test_errors();
    test_stall_flush();
    test_back_to_back_rbw();
`ifdef IMEM_PARITY_EN
    test_parity();
`endif
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule
